// File: rtl/mmio_uart_rx.sv
// mmio_uart_rx: memory-mapped UART receiver.
// Oversamples the asynchronous rx line, deframes 8N1 bytes into a small FIFO and exposes the
// FIFO head and a status word to MEM-stage loads.
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   uart_rx_wire asynchronous serial input, idles high
//   mem_addr     MEM-stage effective address
//   mem_read_en  MEM-stage load strobe, one cycle per load
//   mmio_hit     mem_addr decodes to one of this block's registers (combinational)
//   rdata        load data (combinational)
//   rx_irq       registered; high while the FIFO is non-empty or a sticky error is set
// Status word: {28'b0, ferr, ovr, full, ~empty}; reading it clears ferr and ovr.
module mmio_uart_rx #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CLKS_PER_BIT = 434,
  parameter int unsigned     FIFO_DEPTH   = 8,
  parameter logic [XLEN-1:0] RX_DATA_ADDR = XLEN'(32'h8000_0008),
  parameter logic [XLEN-1:0] RX_STAT_ADDR = XLEN'(32'h8000_000C)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx_wire,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mem_read_en,
  output logic            mmio_hit,
  output logic [XLEN-1:0] rdata,
  output logic            rx_irq
);

  localparam int unsigned     CntW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned     PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] HalfLast  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  // Cleared by a framing error so a held-low line (break) cannot restart a frame until it
  // has returned high.
  logic            armed_q, armed_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d, rx_irq_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic push_req, ferr_evt, push, pop, ovr_set, stat_clr;
  logic data_sel, stat_sel, empty, full;

  // Receive FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    armed_d   = armed_q;
    push_req  = 1'b0;
    ferr_evt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;  // glitch
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s_q) begin
            push_req = 1'b1;
          end else begin
            ferr_evt = 1'b1;
            armed_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO, sticky errors and bus decode.
  always_comb begin
    data_sel = (mem_addr == RX_DATA_ADDR);
    stat_sel = (mem_addr == RX_STAT_ADDR);
    mmio_hit = data_sel | stat_sel;
    empty    = (count_q == '0);
    full     = (count_q == CountFull);
    pop      = mem_read_en & data_sel & ~empty;
    // A pop on the same edge frees the slot the push lands in.
    push     = push_req & (~full | pop);
    ovr_set  = push_req & full & ~pop;
    stat_clr = mem_read_en & stat_sel;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;

    // Set wins over clear.
    ovr_d    = (ovr_q & ~stat_clr) | ovr_set;
    ferr_d   = (ferr_q & ~stat_clr) | ferr_evt;
    rx_irq_d = (count_d != '0) | ovr_d | ferr_d;

    rdata = '0;
    if (data_sel && !empty) begin
      rdata = XLEN'(fifo_q[rd_ptr_q]);
    end else if (stat_sel) begin
      rdata = XLEN'({ferr_q, ovr_q, full, ~empty});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      armed_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx_wire;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      rx_irq    <= rx_irq_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= shreg_q;
  end

endmodule
